// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default baud divisor and the
// frame-entry payload used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DEF_BAUD_DIVISOR = 868;
  localparam int unsigned CNT_W            = 14;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } uart_frame_t;

  // Parity error for 8 data bits plus the received parity bit.
  function automatic logic parity_err_f(input logic [DATA_W:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// Receive holding buffer for uart_rx: one entry (DEPTH=1) or a small ring FIFO.
// Push while full without a pop drops the new frame and sets sticky overrun.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  uart_frame_t din,
  output uart_frame_t dout,
  output logic        full,
  output logic        empty,
  output logic        overrun
);

  logic pop_ok;
  logic push_ok;
  logic overrun_q, overrun_d;

  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign overrun_d = overrun_q | (push & full & ~pop_ok);
  assign overrun   = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  if (DEPTH == 1) begin : g_single
    uart_frame_t ent_q, ent_d;
    logic        vld_q, vld_d;

    // Popping leaves the last entry visible; only the valid flag drops.
    always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (pop_ok) vld_d = 1'b0;
      if (push_ok) begin
        ent_d = din;
        vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ent_q <= '0;
        vld_q <= 1'b0;
      end else begin
        ent_q <= ent_d;
        vld_q <= vld_d;
      end
    end

    assign dout  = ent_q;
    assign full  = vld_q;
    assign empty = ~vld_q;
  end else begin : g_fifo
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    uart_frame_t          mem_q [DEPTH];
    uart_frame_t          mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        mem_q    <= mem_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB first, parity, 1 or 2 stop bits, mid-bit sampling.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-deep FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIVISOR = DEF_BAUD_DIVISOR,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_en,
  input  logic       Two_stop,
  input  logic       Odd_parity,
  input  logic       Rx_in,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       Rx_busy
);

`ifdef UART_RX_FIFO_EN
  localparam int unsigned BUF_DEPTH = 4;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(BAUD_DIVISOR / 2 - 1);

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_W:0]        shreg_q, shreg_d;
  logic                   two_stop_q, two_stop_d;
  logic                   odd_q, odd_d;
  logic                   ferr_q, ferr_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q;
  logic                   busy_q, busy_d;

  logic                   rx_s;
  logic                   fall_c;
  logic                   baud_eq_c;
  logic                   commit_c;
  logic                   ferr_c;
  uart_frame_t            frame_c;
  uart_frame_t            buf_dout;
  logic                   buf_full;
  logic                   buf_empty;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], Rx_in};
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fall_c    = ~rx_s & rx_prev_q;
  assign baud_eq_c = (state_q != IDLE) &&
                     (cnt_q == ((state_q == START) ? HALF_TERM : FULL_TERM));

  // Next-state, bit shifting and commit decode; Rx_en low overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    two_stop_d = two_stop_q;
    odd_d      = odd_q;
    ferr_d     = ferr_q;
    ferr_c     = ferr_q;
    commit_c   = 1'b0;
    if (baud_eq_c) cnt_d = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Rx_en && fall_c) state_d = START;
      end
      START: begin
        if (baud_eq_c) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            two_stop_d = Two_stop;
            odd_d      = Odd_parity;
            bit_cnt_d  = '0;
            ferr_d     = 1'b0;
          end
        end
      end
      DATA: begin
        if (baud_eq_c) begin
          shreg_d   = {shreg_q[DATA_W], rx_s, shreg_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (baud_eq_c) begin
          shreg_d[DATA_W] = rx_s;
          state_d         = STOP1;
        end
      end
      STOP1: begin
        if (baud_eq_c) begin
          ferr_c = ~rx_s;
          if (two_stop_q) begin
            ferr_d  = ~rx_s;
            state_d = STOP2;
          end else begin
            commit_c = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      STOP2: begin
        if (baud_eq_c) begin
          ferr_c   = ferr_q | ~rx_s;
          commit_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!Rx_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      commit_c = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    frame_c = '{data: shreg_q[DATA_W-1:0],
                perr: parity_err_f(shreg_q, odd_q),
                ferr: ferr_c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      two_stop_q <= 1'b0;
      odd_q      <= 1'b0;
      ferr_q     <= 1'b0;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      two_stop_q <= two_stop_d;
      odd_q      <= odd_d;
      ferr_q     <= ferr_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_s;
      busy_q     <= busy_d;
    end
  end

  uart_rx_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (commit_c),
    .pop     (rd_en),
    .din     (frame_c),
    .dout    (buf_dout),
    .full    (buf_full),
    .empty   (buf_empty),
    .overrun (overrun)
  );

  assign rx_data    = buf_dout.data;
  assign parity_err = buf_dout.perr;
  assign frame_err  = buf_dout.ferr;
  assign rx_valid   = ~buf_empty;
  assign Rx_busy    = busy_q;

  logic unused_full;
  assign unused_full = buf_full;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIVISOR=16: vector table, scoreboard
// queue of expected frames, and hand-written abort/overrun/false-start sequences.
module tb_uart_rx;

  localparam int unsigned BAUD = 16;
  localparam int unsigned LAT1 = BAUD * 10 + 11;
  localparam int unsigned LAT2 = BAUD * 11 + 11;

  logic       clk = 1'b0;
  logic       rst, Rx_en, Two_stop, Odd_parity, Rx_in, rd_en;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, Rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic       two;
    logic       bad_par;
    logic       s1;
    logic       s2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  int   rise_cyc  = -1;
  logic arm       = 1'b0;
  logic vprev     = 1'b0;

  uart_rx #(
    .BAUD_DIVISOR (BAUD),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx_en      (Rx_en),
    .Two_stop   (Two_stop),
    .Odd_parity (Odd_parity),
    .Rx_in      (Rx_in),
    .rd_en      (rd_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .Rx_busy    (Rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Commit latency monitor: cycles from start-bit drive to the rx_valid rise.
  always @(negedge clk) begin
    if (arm && rx_valid === 1'b1 && vprev === 1'b0) begin
      rise_cyc = cyc - start_cyc;
      arm      = 1'b0;
    end
    vprev = rx_valid;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_drive(input logic b);
    Rx_in = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic two,
                            input logic s1, input logic s2);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bit_drive(1'b0);
    for (int i = 0; i < 8; i++) bit_drive(d[i]);
    bit_drive(p);
    bit_drive(s1);
    if (two) bit_drive(s2);
    Rx_in = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Good frame with the current Odd_parity/Two_stop settings; optionally expected.
  task automatic send_good(input logic [7:0] d, input logic expect_it);
    if (expect_it) sb_q.push_back('{data: d, perr: 1'b0, ferr: 1'b0});
    send_frame(d, good_par(d, Odd_parity), Two_stop, 1'b1, 1'b1);
  endtask

  task automatic expect_frame(input string tag, input logic exp_after);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (rx_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    if (rx_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_sb: got data %02h expected no pending frame", tag, rx_data);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_data"}, 32'(rx_data), 32'(e.data));
        chk({tag, "_perr"}, 32'(parity_err), 32'(e.perr));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(e.ferr));
      end
    end
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_after_pop"}, 32'(rx_valid), 32'(exp_after));
  endtask

  // Start bit plus data bits 0..3 of 0xFF, leaving the line mid data bit 4.
  task automatic partial_ff();
    @(posedge clk);
    #1;
    bit_drive(1'b0);
    for (int i = 0; i < 4; i++) bit_drive(1'b1);
    repeat (BAUD / 2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; Rx_en = 1'b1; Two_stop = 1'b0; Odd_parity = 1'b0;
    Rx_in = 1'b1; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(Rx_busy), 32'h0);

    // Table-driven frames: parity/stop variants, latency and flags.
    for (int v = 0; v < 8; v++) begin
      Odd_parity = vecs[v].odd;
      Two_stop   = vecs[v].two;
      sb_q.push_back('{data: vecs[v].data, perr: vecs[v].bad_par,
                       ferr: ~vecs[v].s1 | (vecs[v].two & ~vecs[v].s2)});
      rise_cyc = -1;
      arm      = 1'b1;
      send_frame(vecs[v].data, good_par(vecs[v].data, vecs[v].odd) ^ vecs[v].bad_par,
                 vecs[v].two, vecs[v].s1, vecs[v].s2);
      @(negedge clk);
      chk($sformatf("vec%0d_latency", v), 32'(rise_cyc), vecs[v].two ? LAT2 : LAT1);
      expect_frame($sformatf("vec%0d", v), 1'b0);
    end
    Odd_parity = 1'b0;
    Two_stop   = 1'b0;

    // False start: 5-cycle low glitch.
    @(posedge clk);
    #1 Rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 Rx_in = 1'b1;
    @(negedge clk);
    chk("false_start_busy_high", 32'(Rx_busy), 32'd1);
    repeat (20) @(negedge clk);
    chk("false_start_busy_low", 32'(Rx_busy), 32'd0);
    chk("false_start_no_valid", 32'(rx_valid), 32'd0);

    // Commit and pop on the same edge with the buffer holding one byte.
    send_good(8'h3A, 1'b0);
    fork
      send_good(8'hC3, 1'b1);
      begin
        @(posedge clk);
        repeat (LAT1 - 1) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    @(negedge clk);
    chk("pushpop_overrun", 32'(overrun), 32'd0);
    expect_frame("pushpop", 1'b0);

    // Overrun: frames arrive with no reads until the buffer is full.
`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 5; i++) send_good(8'h10 + 8'(i), i < 4);
    @(negedge clk);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) expect_frame($sformatf("ovr_pop%0d", i), i < 3);
`else
    send_good(8'h11, 1'b1);
    send_good(8'h22, 1'b0);
    @(negedge clk);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_keep_old", 32'(rx_data), 32'h11);
    expect_frame("ovr", 1'b0);
    chk("ovr_data_hold", 32'(rx_data), 32'h11);
`endif
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during data bit 4 discards the frame and clears overrun.
    partial_ff();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_overrun", 32'(overrun), 32'd0);
    chk("rst_abort_busy", 32'(Rx_busy), 32'd0);
    repeat (BAUD * 8) @(negedge clk);
    chk("rst_abort_no_valid", 32'(rx_valid), 32'd0);
    send_good(8'h55, 1'b1);
    expect_frame("after_rst", 1'b0);

    // Rx_en drop mid-frame leaves the buffered byte untouched.
    send_good(8'h77, 1'b1);
    partial_ff();
    Rx_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("en_abort_busy", 32'(Rx_busy), 32'd0);
    #1 Rx_en = 1'b1;
    repeat (BAUD * 8) @(negedge clk);
    chk("en_abort_busy_idle", 32'(Rx_busy), 32'd0);
    expect_frame("en_keep", 1'b0);
    send_good(8'h55, 1'b1);
    expect_frame("after_en", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that is the far-end counterpart of the team's UART transmitter. It uses the same frame format: 1 start bit, 8 data bits LSB first, 1 parity bit (odd or even), then 1 or 2 stop bits, at a fixed baud set by a clock divisor. It synchronises the serial line, samples each bit at mid-bit, checks parity and stop bits, and presents each received byte with error flags through a holding buffer. The consumer pops that buffer with a read strobe. Sits between the board RX pin and the core-side consumer.

Parameters:
BAUD_DIVISOR, 868, clk cycles per bit period (100 MHz / 115200); legal range 4..16383
SYNC_STAGES, 2, flip-flops in the Rx_in metastability synchroniser; legal range 2..3

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
Rx_en  input  1  receiver enable; low holds the FSM in IDLE and aborts any frame in progress
Two_stop  input  1  1 = two stop bits expected, 0 = one; sampled at start-bit confirm
Odd_parity  input  1  1 = odd parity, 0 = even; sampled at start-bit confirm
Rx_in  input  1  asynchronous serial line; idle high
rd_en  input  1  pops the buffered byte when rx_valid=1; ignored when rx_valid=0
rx_data  output  8  buffered byte
rx_valid  output  1  buffer holds an unread byte
parity_err  output  1  parity mismatch for the byte on rx_data
frame_err  output  1  a stop bit sampled low for the byte on rx_data
overrun  output  1  sticky: a completed frame was dropped because the buffer was full
Rx_busy  output  1  FSM not in IDLE

Behaviour:
- Reset: FSM to IDLE; counters 0; synchroniser flops to 1. Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, Rx_busy=0. Reset mid-frame discards the partial frame.
- Rx_in passes through SYNC_STAGES flops; all decisions use the synchronised value rx_s. A falling edge is rx_s=0 with the previous rx_s=1.
- 14-bit baud counter, reloaded on each state entry; baud_eq is asserted when the count reaches the state's terminal value.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on a falling edge with Rx_en=1, go to START and clear the counter.
- START: wait BAUD_DIVISOR/2 cycles (integer division), then sample rx_s.
  - rx_s=1: false start, return to IDLE with no side effects.
  - rx_s=0: latch Two_stop and Odd_parity into internal registers, go to DATA.
- DATA: every BAUD_DIVISOR cycles, shift rx_s into bit 7 of a 9-bit shift register (right shift, so LSB arrives first). A 3-bit bit counter tracks data bits; after the 8th sample go to PARITY.
- PARITY: after BAUD_DIVISOR cycles, sample the parity bit.
  - perr = XOR(data bits, parity bit) XOR latched Odd_parity.
  - Even parity: error when the XOR of all 9 bits is 1. Odd parity: error when it is 0.
- STOP1: after BAUD_DIVISOR cycles, sample rx_s; ferr = ~rx_s.
  - Latched Two_stop=0: commit the frame and go to IDLE in the same cycle.
  - Latched Two_stop=1: go to STOP2.
- STOP2: after BAUD_DIVISOR cycles, sample rx_s; OR ~rx_s into ferr, commit the frame, go to IDLE.
- Frames are committed at the mid-bit of the last stop bit. This permits back-to-back frames and a receive clock up to ~half a bit fast.
- Commit latency: rx_valid, rx_data and the error flags update on the clock edge after the final stop sample. That is 1 cycle after the last baud_eq.
- Buffer (1 entry, stores {data, perr, ferr}):
  - commit, buffer empty: store the frame, rx_valid goes to 1.
  - commit and rd_en on the same cycle, buffer full: pop and store in the same cycle; rx_valid stays 1; no overrun.
  - commit, buffer full, no rd_en: drop the new frame, keep the old one, set overrun=1.
  - rd_en with buffer full, no commit: rx_valid goes to 0. rx_data and the error flags hold their last value.
- overrun is cleared only by rst.
- Rx_en falling mid-frame: go to IDLE on the next edge; nothing is committed; buffer contents are untouched.
- A frame with ferr=1 is still committed, with frame_err=1. No break detection.

Optional Feature:
UART_RX_FIFO_EN
- Defined: the single-entry buffer becomes a 4-deep FIFO of {data, perr, ferr}.
  - rx_valid = not empty; rx_data and the flags show the head entry.
  - Overrun when a commit arrives with 4 entries held and no rd_en; the new frame is dropped.
  - Simultaneous push and pop at full is legal, with no overrun.
  - Pointers are 2 bits and wrap modulo 4; the count is 3 bits.
- Undefined: single-entry buffer exactly as described in Behaviour.

Decomposition:
- uart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP1, STOP2}
  - BAUD_DIVISOR default constant
  - the frame-entry struct {data[7:0], perr, ferr}
- The transmitter shares BAUD_DIVISOR and the struct.
- One sub-module, uart_rx_buf: parameterised depth (1 or 4); push/pop/full/empty/overrun; instantiated once.

Test Plan:
- BAUD_DIVISOR=16, Odd_parity=0, Two_stop=0; send 0xA5 with parity 0 and stop 1 → rx_valid rises 1 cycle after the stop mid-sample; rx_data=0xA5, parity_err=0, frame_err=0.
- Odd_parity=1; send 0x3C with parity 1 → parity_err=0. Resend 0x3C with parity 0 → parity_err=1, rx_data=0x3C.
- Two_stop=1; send 0x81 with the second stop bit driven 0 → frame_err=1. The next frame 0x81 with both stops high → frame_err=0.
- Send 0x11 then 0x22 with no rd_en → rx_data=0x11, overrun=1. With UART_RX_FIFO_EN, the 5th unread frame sets overrun and the FIFO pops 4 entries in order.
- Rx_in low pulse of 5 cycles at BAUD_DIVISOR=16 → false start: Rx_busy returns to 0, rx_valid stays 0.
- Assert rst (or deassert Rx_en) during data bit 4 of 0xFF → no commit. The next full frame 0x55 is received correctly.
